pipe_stage_reg: RTL and testbench

// - Pipeline latch between two stages. Consumes the stall/flush/freeze controls that the hazard logic generates.
// - Holds a valid bit plus an opaque payload bus.
// - Flushes that arrive during a memory wait are kept pending and applied at the next advance.
// - Optional saturating hazard-event counters for performance debug.
// - One instance per stage boundary: IF/ID, ID/EX, EX/MEM, MEM/WB.
//

---
 rtl/pipe_stage_reg_if.sv | 24 ++
 rtl/pipe_stage_reg.sv | 110 +++++++++++
 tb/tb_pipe_stage_reg.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Stage-boundary bundle: advance/hold/squash controls, upstream payload and latched outputs.
// master drives controls and payload; slave is the pipeline latch.
interface pipe_stage_reg_if #(
   parameter int unsigned DATA_W = 64
);
   logic              en;
   logic              freeze;
   logic              flush;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              flush_pend;

   modport master (
      output en, freeze, flush, in_valid, in_data,
      input  out_valid, out_data, flush_pend
   );

   modport slave (
      input  en, freeze, flush, in_valid, in_data,
      output out_valid, out_data, flush_pend
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline latch with stall/freeze/flush handling and a deferred-flush FSM.
// Define PIPE_PERF_CNT_EN to build the saturating hazard-event counters.
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                CLK,
   input  logic                nRST,
   pipe_stage_reg_if.slave     bus,
   input  logic                clr_cnt,
   output logic [CNT_W-1:0]    flush_cnt,
   output logic [CNT_W-1:0]    freeze_cnt,
   output logic [CNT_W-1:0]    bubble_cnt
);

   typedef enum logic [0:0] {StRun, StFlushWait} state_e;

   state_e            state_q, state_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              load;
   logic              flush_inc, freeze_inc, bubble_inc;

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      data_d     = data_q;
      load       = 1'b0;
      flush_inc  = 1'b0;
      freeze_inc = 1'b0;
      unique case (state_q)
         StRun: begin
            if (bus.flush && bus.en) begin
               valid_d   = 1'b0;
               data_d    = '0;
               load      = 1'b1;
               flush_inc = 1'b1;
            end else if (bus.flush) begin
               state_d = StFlushWait;
            end else if (bus.freeze) begin
               freeze_inc = 1'b1;
            end else if (bus.en) begin
               valid_d = bus.in_valid;
               data_d  = bus.in_data;
               load    = 1'b1;
            end
         end
         StFlushWait: begin
            // Pending flush wins over freeze; repeated flushes here are absorbed.
            if (bus.en) begin
               valid_d   = 1'b0;
               data_d    = '0;
               load      = 1'b1;
               flush_inc = 1'b1;
               state_d   = StRun;
            end
         end
         default: state_d = StRun;
      endcase
      bubble_inc = load && !valid_d;
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= StRun;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign bus.out_valid  = valid_q;
   assign bus.out_data   = data_q;
   assign bus.flush_pend = (state_q == StFlushWait);

`ifdef PIPE_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic [CNT_W-1:0] flush_cnt_q, freeze_cnt_q, bubble_cnt_q;

   // Clear takes precedence over any increment in the same cycle.
   always_ff @(posedge CLK) begin
      if (!nRST || clr_cnt) begin
         flush_cnt_q  <= '0;
         freeze_cnt_q <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (flush_inc && (flush_cnt_q != CntMax))   flush_cnt_q  <= flush_cnt_q + CntOne;
         if (freeze_inc && (freeze_cnt_q != CntMax)) freeze_cnt_q <= freeze_cnt_q + CntOne;
         if (bubble_inc && (bubble_cnt_q != CntMax)) bubble_cnt_q <= bubble_cnt_q + CntOne;
      end
   end

   assign flush_cnt  = flush_cnt_q;
   assign freeze_cnt = freeze_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`else
   logic unused_perf;
   assign unused_perf = ^{clr_cnt, flush_inc, freeze_inc, bubble_inc};

   assign flush_cnt  = '0;
   assign freeze_cnt = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios then random traffic
// compared against a behavioural model. Counter expectations follow PIPE_PERF_CNT_EN.
module tb_pipe_stage_reg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned CNT_W  = 4;
   localparam int          CMAX   = (1 << CNT_W) - 1;

   logic             CLK = 1'b0;
   logic             nRST;
   logic             clr_cnt;
   logic [CNT_W-1:0] flush_cnt, freeze_cnt, bubble_cnt;

   pipe_stage_reg_if #(.DATA_W(DATA_W)) bus ();

   pipe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .bus        (bus),
      .clr_cnt    (clr_cnt),
      .flush_cnt  (flush_cnt),
      .freeze_cnt (freeze_cnt),
      .bubble_cnt (bubble_cnt)
   );

   always #5 CLK = ~CLK;

   int n_asserts = 0;
   int n_fail    = 0;

   // Reference model state
   bit              m_valid;
   logic [63:0]     m_data;
   bit              m_pend;
   int              m_flush, m_freeze, m_bubble;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat_inc(input int v, input bit inc);
      return (inc && v < CMAX) ? v + 1 : v;
   endfunction

   function automatic int perf(input int v);
`ifdef PIPE_PERF_CNT_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   task automatic model_edge(input bit r, input bit e, input bit fz, input bit fl,
                             input bit iv, input logic [63:0] d, input bit clr);
      bit loaded, lval, fi, zi;
      loaded = 0; lval = 0; fi = 0; zi = 0;
      if (!r) begin
         m_valid = 0; m_data = '0; m_pend = 0;
         m_flush = 0; m_freeze = 0; m_bubble = 0;
         return;
      end
      if (m_pend || fl) begin
         // Any flush (new or pending) squashes at the next advance.
         if (e) begin
            loaded = 1; lval = 0; fi = 1; m_pend = 0;
            m_valid = 0; m_data = '0;
         end else begin
            m_pend = 1;
         end
      end else if (fz) begin
         zi = 1;
      end else if (e) begin
         loaded = 1; lval = iv; m_valid = iv; m_data = d;
      end
      if (clr) begin
         m_flush = 0; m_freeze = 0; m_bubble = 0;
      end else begin
         m_flush  = sat_inc(m_flush, fi);
         m_freeze = sat_inc(m_freeze, zi);
         m_bubble = sat_inc(m_bubble, loaded && !lval);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".valid"},  64'(bus.out_valid),  64'(m_valid));
      check({tag, ".data"},   bus.out_data,        m_data);
      check({tag, ".pend"},   64'(bus.flush_pend), 64'(m_pend));
      check({tag, ".fcnt"},   64'(flush_cnt),      64'(perf(m_flush)));
      check({tag, ".zcnt"},   64'(freeze_cnt),     64'(perf(m_freeze)));
      check({tag, ".bcnt"},   64'(bubble_cnt),     64'(perf(m_bubble)));
   endtask

   task automatic step(input string tag, input bit r, input bit e, input bit fz, input bit fl,
                       input bit iv, input logic [63:0] d, input bit clr);
      nRST         = r;
      bus.en       = e;
      bus.freeze   = fz;
      bus.flush    = fl;
      bus.in_valid = iv;
      bus.in_data  = d;
      clr_cnt      = clr;
      @(posedge CLK);
      model_edge(r, e, fz, fl, iv, d, clr);
      #1;
      check_all(tag);
   endtask

   initial begin
      m_valid = 0; m_data = '0; m_pend = 0; m_flush = 0; m_freeze = 0; m_bubble = 0;

      // Reset dominates active inputs
      step("rst0", 0, 1, 0, 0, 1, 64'd5, 0);
      step("rst1", 0, 1, 0, 0, 1, 64'd5, 0);
      check("rst.valid0", 64'(bus.out_valid), 64'd0);
      check("rst.data0",  bus.out_data,       64'd0);

      // Advance then hold
      step("adv", 1, 1, 0, 0, 1, 64'hABCD, 0);
      check("adv.data_const", bus.out_data, 64'hABCD);
      for (int i = 0; i < 3; i++) step("hold", 1, 0, 0, 0, 1, 64'h1111, 0);
      check("hold.data_const", bus.out_data, 64'hABCD);

      // Deferred flush
      step("ld7",   1, 1, 0, 0, 1, 64'd7, 0);
      step("dflsh", 1, 0, 0, 1, 1, 64'd8, 0);
      check("dflsh.pend_const", 64'(bus.flush_pend), 64'd1);
      check("dflsh.data_const", bus.out_data, 64'd7);
      step("wait0", 1, 0, 1, 1, 1, 64'd8, 0);
      step("wait1", 1, 0, 0, 0, 1, 64'd8, 0);
      step("apply", 1, 1, 0, 0, 1, 64'd9, 0);
      check("apply.data_const", bus.out_data, 64'd0);
`ifdef PIPE_PERF_CNT_EN
      check("apply.fcnt_const", 64'(flush_cnt), 64'd1);
`endif

      // Priority: flush beats freeze, then freeze holds against en
      step("clr",  1, 0, 0, 0, 0, 64'd0, 1);
      step("ld3",  1, 1, 0, 0, 1, 64'd3, 0);
      step("prio", 1, 1, 1, 1, 1, 64'd4, 0);
      for (int i = 0; i < 4; i++) step("frz", 1, 1, 1, 0, 1, 64'd6, 0);
`ifdef PIPE_PERF_CNT_EN
      check("frz.zcnt_const", 64'(freeze_cnt), 64'd4);
`endif

      // Saturation and clear
      for (int i = 0; i < 20; i++) step("sat", 1, 1, 0, 1, 1, 64'd2, 0);
`ifdef PIPE_PERF_CNT_EN
      check("sat.fcnt_const", 64'(flush_cnt), 64'(CMAX));
`endif
      step("satclr", 1, 1, 0, 1, 1, 64'd2, 1);
      check("satclr.fcnt_const", 64'(flush_cnt), 64'd0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step("rand",
              ($urandom_range(0, 31) != 0),
              ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) != 0),
              {$urandom, $urandom},
              ($urandom_range(0, 15) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
